// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the
// instruction handshake towards decode.
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests a word, holds it for
// decode, and redirects on taken branches / jumps with stale-response kill.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] pc_target,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign redirect = PCSrc | Jump;
    assign target   = pc_target & ~32'h3;
    assign next_pc  = redirect ? target : pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            pc                 <= START_PC;
            kill               <= 1'b0;
            fetch_count        <= 32'd0;
            bus.imem_req_valid <= 1'b0;
            bus.imem_addr      <= START_PC;
            bus.instr_valid    <= 1'b0;
            bus.instruction    <= NOP;
            bus.instr_pc       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state              <= FETCH;
                    bus.imem_req_valid <= 1'b1;
                    bus.imem_addr      <= pc;
                end
                FETCH: begin
                    if (redirect)
                        pc <= target;
                    // The address on the bus may predate an earlier redirect;
                    // in that case the accepted request is already stale.
                    if (bus.imem_req_ready) begin
                        bus.imem_req_valid <= 1'b0;
                        state              <= WAIT;
                        kill               <= redirect || (bus.imem_addr != pc);
                    end
                end
                WAIT: begin
                    if (redirect)
                        pc <= target;
                    if (bus.imem_resp_valid) begin
                        if (kill || redirect) begin
                            kill               <= 1'b0;
                            state              <= FETCH;
                            bus.imem_req_valid <= 1'b1;
                            bus.imem_addr      <= redirect ? target : pc;
                        end else begin
                            bus.instruction <= bus.imem_resp_data;
                            bus.instr_pc    <= pc;
                            bus.instr_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // A redirect coinciding with consumption still counts the
                    // instruction but steers the next fetch to the target.
                    if (redirect || bus.instr_ready) begin
                        pc                 <= next_pc;
                        bus.imem_addr      <= next_pc;
                        bus.imem_req_valid <= 1'b1;
                        bus.instr_valid    <= 1'b0;
                        state              <= FETCH;
                        if (bus.instr_ready)
                            fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder, a reference model of the
// expected fetch stream checked every cycle, and hand-computed checkpoints.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic        Jump;
    logic [31:0] pc_target;
    logic [31:0] fetch_count;
    int          cyc = 0;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .pc_target   (pc_target),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory contents: each word encodes the low half of its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    // Memory knobs, written by the stimulus process at negedges only.
    int          mem_lat   = 0;
    bit          ready_en  = 1'b1;
    bit          keep_late = 1'b0;
    bit          ovr_en    = 1'b0;
    logic [31:0] ovr_data  = 32'h0;
    logic [31:0] acc_log[$];

    // Memory responder: one response per accepted request, mem_lat cycles late.
    initial begin
        logic        acc;
        logic [31:0] a;
        bit          pending;
        int          cnt;
        logic [31:0] pdata;
        pending = 1'b0;
        cnt     = 0;
        pdata   = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            acc = bus.imem_req_valid && bus.imem_req_ready && !rst;
            a   = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (rst && !keep_late)
                pending = 1'b0;
            if (acc) begin
                pending = 1'b1;
                cnt     = mem_lat;
                pdata   = ovr_en ? ovr_data : mem_word(a);
                acc_log.push_back(a);
            end
            if (pending) begin
                if (cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = pdata;
                    pending             = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.imem_req_ready = ready_en;
        end
    end

    // Reference model: the program counter decode should see next, and the
    // number of instructions it has consumed; checked on every cycle.
    initial begin
        logic [31:0] exp_pc, exp_cnt, p_addr, p_instr, p_ipc;
        bit          p_req, p_rdy, p_iv, p_irdy, p_redir;
        int          since;
        exp_pc = 32'h0; exp_cnt = 32'h0; p_addr = 32'h0; p_instr = 32'h0; p_ipc = 32'h0;
        p_req = 0; p_rdy = 0; p_iv = 0; p_irdy = 0; p_redir = 0; since = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = 32'h0; exp_cnt = 32'h0; since = 0;
                p_req = 0; p_rdy = 0; p_iv = 0; p_irdy = 0; p_redir = 0;
            end else begin
                chk("m_fetch_count", fetch_count, exp_cnt);
                chk("m_addr_align", {30'b0, bus.imem_addr[1:0]}, 32'h0);
                chk("m_one_outstanding", 32'(bus.imem_req_valid && bus.instr_valid), 32'h0);
                if (bus.imem_req_valid && !p_req)
                    chk("m_req_addr", bus.imem_addr, exp_pc);
                if (p_req && !p_rdy) begin
                    chk("m_req_hold_valid", 32'(bus.imem_req_valid), 32'h1);
                    chk("m_req_hold_addr", bus.imem_addr, p_addr);
                end
                if (bus.instr_valid && !p_iv) begin
                    chk("m_instr_pc", bus.instr_pc, exp_pc);
                    chk("m_instr_word", bus.instruction, mem_word(exp_pc));
                end
                if (p_iv && !p_irdy && !p_redir) begin
                    chk("m_hold_valid", 32'(bus.instr_valid), 32'h1);
                    chk("m_hold_word", bus.instruction, p_instr);
                    chk("m_hold_pc", bus.instr_pc, p_ipc);
                end
                if (p_iv && (p_irdy || p_redir))
                    chk("m_instr_retire", 32'(bus.instr_valid), 32'h0);
                if ((PCSrc || Jump) && since > 0)
                    exp_pc = pc_target & ~32'h3;
                else if (bus.instr_valid && bus.instr_ready)
                    exp_pc = exp_pc + 32'd4;
                if (bus.instr_valid && bus.instr_ready)
                    exp_cnt = exp_cnt + 32'd1;
                since++;
                p_req   = bus.imem_req_valid;
                p_rdy   = bus.imem_req_ready;
                p_addr  = bus.imem_addr;
                p_iv    = bus.instr_valid;
                p_irdy  = bus.instr_ready;
                p_redir = PCSrc || Jump;
                p_instr = bus.instruction;
                p_ipc   = bus.instr_pc;
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
        chk({tag, "_addr"}, bus.imem_addr, 32'h0);
        chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'h0);
        chk({tag, "_instruction"}, bus.instruction, 32'h0000_0013);
        chk({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
        chk({tag, "_fetch_count"}, fetch_count, 32'h0);
    endtask

    task automatic wait_instr(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.instr_valid && n < 60);
        chk({tag, "_instr_arrives"}, 32'(bus.instr_valid), 32'h1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.imem_req_valid && n < 60);
        chk({tag, "_req_arrives"}, 32'(bus.imem_req_valid), 32'h1);
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.imem_req_valid && bus.imem_req_ready) && n < 60);
        chk({tag, "_accept"}, 32'(bus.imem_req_valid && bus.imem_req_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] h_instr, h_pc, h_cnt;
        int          last;
        rst = 1'b1; PCSrc = 1'b0; Jump = 1'b0; pc_target = 32'h0;
        bus.instr_ready = 1'b0;
        last = 0;
        repeat (2) @(negedge clk);
        reset_checks("reset");

        // Sequential fetch with zero-wait memory and an always-ready decoder.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_instr("seq");
            chk("seq_pc", bus.instr_pc, pcs[i]);
            chk("seq_word", bus.instruction, mem_word(pcs[i]));
            if (i > 0)
                chk("seq_cycles_per_instr", 32'(cyc - last), 32'd3);
            last = cyc;
        end
        @(negedge clk);
        chk("seq_fetch_count", fetch_count, 32'd3);
        for (int i = 0; i < 3; i++)
            chk("seq_imem_addr", (acc_log.size() > i) ? acc_log[i] : 32'hxxxx_xxxx, pcs[i]);

        // Decoder stalls for five cycles while an instruction is held.
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        wait_instr("stall");
        h_instr = bus.instruction; h_pc = bus.instr_pc; h_cnt = fetch_count;
        chk("stall_pc_value", h_pc, 32'h0000_000C);
        chk("stall_count_value", h_cnt, 32'd3);
        repeat (5) begin
            @(negedge clk);
            chk("stall_word", bus.instruction, h_instr);
            chk("stall_pc", bus.instr_pc, h_pc);
            chk("stall_count", fetch_count, h_cnt);
            chk("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
        end
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;

        // Jump while waiting on a slow response: that response must be dropped.
        @(negedge clk);
        mem_lat = 3; ovr_data = 32'hDEAD_BEEF; ovr_en = 1'b1;
        wait_accept("jump_wait");
        @(posedge clk); #1;
        Jump = 1'b1; pc_target = 32'h0000_0103;
        @(posedge clk); #1;
        Jump = 1'b0;
        @(negedge clk);
        ovr_en = 1'b0; mem_lat = 0;
        wait_req("jump_wait");
        chk("jump_next_addr", bus.imem_addr, 32'h0000_0100);
        wait_instr("jump_wait");
        chk("jump_instr_pc", bus.instr_pc, 32'h0000_0100);
        chk("jump_instr_word", bus.instruction, 32'h0100_0013);

        // Jump in HOLD to 0x20, then branch to 0x40 while decode consumes.
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        wait_instr("hold_jump");
        @(posedge clk); #1;
        Jump = 1'b1; pc_target = 32'h0000_0020;
        @(posedge clk); #1;
        Jump = 1'b0;
        wait_instr("branch");
        chk("branch_pc_0x20", bus.instr_pc, 32'h0000_0020);
        chk("branch_count_before", fetch_count, 32'd5);
        @(posedge clk); #1;
        PCSrc = 1'b1; pc_target = 32'h0000_0040; bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        PCSrc = 1'b0; bus.instr_ready = 1'b0;
        @(negedge clk);
        chk("branch_count_after", fetch_count, 32'd6);
        chk("branch_instr_dropped", 32'(bus.instr_valid), 32'h0);
        chk("branch_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("branch_next_addr", bus.imem_addr, 32'h0000_0040);
        wait_instr("branch");
        chk("branch_instr_pc", bus.instr_pc, 32'h0000_0040);

        // Address wrap from the top of the address space.
        @(posedge clk); #1;
        Jump = 1'b1; pc_target = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        Jump = 1'b0;
        wait_instr("wrap");
        chk("wrap_top_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_top_word", bus.instruction, 32'hFFFC_0013);
        @(posedge clk); #1;
        bus.instr_ready = 1'b1;
        wait_req("wrap");
        chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
        wait_instr("wrap");
        chk("wrap_instr_pc", bus.instr_pc, 32'h0000_0000);
        chk("wrap_count", fetch_count, 32'd7);

        // Reset pulse while waiting; the late response must not be delivered.
        mem_lat = 3; keep_late = 1'b1; ovr_data = 32'hBAD0_0001; ovr_en = 1'b1;
        wait_accept("rst_wait");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        reset_checks("rst_wait");
        @(negedge clk);
        ovr_en = 1'b0; ready_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.imem_resp_valid && n < 20);
        end
        chk("late_resp_seen", 32'(bus.imem_resp_valid), 32'h1);
        chk("late_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("late_req_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        chk("late_resp_ignored", 32'(bus.instr_valid), 32'h0);
        ready_en = 1'b1; keep_late = 1'b0; mem_lat = 0;
        wait_instr("after_rst");
        chk("after_rst_pc", bus.instr_pc, 32'h0);
        chk("after_rst_word", bus.instruction, 32'h0000_0013);
        chk("after_rst_count", fetch_count, 32'h0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
